spi_cmd_controller: RTL and testbench

//  Command sequencer between the SPI slave byte interface and the FPGA-side logic.

---
 rtl/spi_cmd_controller_pkg.sv | 52 +++++
 rtl/sync_2ff.sv | 33 +++
 rtl/spi_cmd_controller.sv | 188 ++++++++++++++++++
 tb/tb_spi_cmd_controller.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_cmd_controller_pkg
//  Brief    : Opcode constants, FSM state encoding and opcode decode helper
//             shared by the SPI command controller and its host-side users.
//  Revision : 1.0  initial release
// ============================================================================
package spi_cmd_controller_pkg;

    // Whole-byte opcodes
    localparam logic [7:0] OP_GET_STATE = 8'hFF;
    localparam logic [7:0] OP_GET_ERR   = 8'hFE;
    localparam logic [7:0] OP_NOP       = 8'h00;

    // Two-bit class prefixes in bits [7:6]; bits [3:0] carry the register address
    localparam logic [1:0] OP_READ      = 2'b10;
    localparam logic [1:0] OP_WRITE     = 2'b01;

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_WAIT_DATA = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        CMD_NOP       = 3'd0,
        CMD_GET_STATE = 3'd1,
        CMD_GET_ERR   = 3'd2,
        CMD_READ      = 3'd3,
        CMD_WRITE     = 3'd4,
        CMD_ILLEGAL   = 3'd5
    } cmd_t;

    // Classify an opcode byte; address range is checked by the caller
    function automatic cmd_t decode_op(input logic [7:0] i_byte);
        cmd_t v_cmd;
        if (i_byte == OP_GET_STATE)
            v_cmd = CMD_GET_STATE;
        else if (i_byte == OP_GET_ERR)
            v_cmd = CMD_GET_ERR;
        else if (i_byte == OP_NOP)
            v_cmd = CMD_NOP;
        else if (i_byte[7:6] == OP_READ)
            v_cmd = CMD_READ;
        else if (i_byte[7:6] == OP_WRITE)
            v_cmd = CMD_WRITE;
        else
            v_cmd = CMD_ILLEGAL;
        return v_cmd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Brief    : Two-flop synchronizer for a single asynchronous level signal.
//  Revision : 1.0  initial release
// ============================================================================
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_D,
    output logic o_Q
);

    logic r_meta;
    logic r_sync;

    // First flop may go metastable; second flop gives it a full cycle to settle
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_D;
            r_sync <= r_meta;
        end
    end

    assign o_Q = r_sync;

endmodule
`default_nettype wire

// File: rtl/spi_cmd_controller.sv
`default_nettype none
// ============================================================================
//  Module   : spi_cmd_controller
//  Brief    : Decodes master bytes from the SPI slave, queues the response byte
//             for the next transfer and owns a small master-written config
//             register file.
//  Revision : 1.0  initial release
// ============================================================================
module spi_cmd_controller
    import spi_cmd_controller_pkg::*;
#(
    parameter int          STATE_W   = 2,
    parameter int          NUM_REGS  = 4,
    parameter logic [7:0]  ACK_BYTE  = 8'hA5,
    parameter logic [7:0]  ERR_BYTE  = 8'hEE,
    parameter logic [7:0]  IDLE_BYTE = 8'h00
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst,
    input  logic                    i_SPI_CS_n,
    input  logic                    i_RX_DV,
    input  logic [7:0]              i_RX_Byte,
    output logic                    o_TX_DV,
    output logic [7:0]              o_TX_Byte,
    input  logic [STATE_W-1:0]      i_Fsm_State,
    output logic [8*NUM_REGS-1:0]   o_Cfg,
    output logic                    o_Cfg_Wr_Stb,
    output logic [3:0]              o_Cfg_Wr_Addr,
    output logic                    o_Busy
);

    // ------------------------------------------------------------------------
    // Chip-select synchronisation and edge detection
    // ------------------------------------------------------------------------
    logic w_cs_sync;
    logic r_cs_prev;
    logic w_cs_rise;
    logic w_cs_fall;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_cs_sync (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .i_D   (i_SPI_CS_n),
        .o_Q   (w_cs_sync)
    );

    // Delayed copy of synchronized CS_n; resets high so reset never looks like a fall
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst)
            r_cs_prev <= 1'b1;
        else
            r_cs_prev <= w_cs_sync;
    end

    assign w_cs_rise = w_cs_sync & ~r_cs_prev;
    assign w_cs_fall = ~w_cs_sync & r_cs_prev;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t      r_state;
    logic [7:0]  r_cfg [NUM_REGS];
    logic [7:0]  r_err_cnt;
    logic [3:0]  r_lat_addr;
    logic        r_tx_dv;
    logic [7:0]  r_tx_byte;
    logic        r_wr_stb;
    logic [3:0]  r_wr_addr;

    // ------------------------------------------------------------------------
    // Decode of the incoming byte
    // ------------------------------------------------------------------------
    logic        w_rx_ok;
    cmd_t        w_cmd;
    logic [3:0]  w_addr;
    logic        w_addr_ok;
    logic [7:0]  w_rd_data;
    logic [7:0]  w_state_byte;
    logic [7:0]  w_err_inc;

    // A byte only counts while the chip is selected (a CS rise implies sync'd high)
    assign w_rx_ok      = i_RX_DV & ~w_cs_sync;
    assign w_cmd        = decode_op(i_RX_Byte);
    assign w_addr       = i_RX_Byte[3:0];
    assign w_addr_ok    = (int'(w_addr) < NUM_REGS);
    assign w_state_byte = 8'(i_Fsm_State);
    assign w_err_inc    = (r_err_cnt == 8'hFF) ? 8'hFF : (r_err_cnt + 8'd1);

    // Read mux over the register file, indexed by the opcode's address field
    always_comb begin
        w_rd_data = 8'h00;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (w_addr == 4'(k))
                w_rd_data = r_cfg[k];
        end
    end

    // ------------------------------------------------------------------------
    // Command FSM: CS edges take priority over any byte arriving the same cycle
    // ------------------------------------------------------------------------
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_state    <= ST_IDLE;
            r_err_cnt  <= 8'h00;
            r_lat_addr <= 4'h0;
            r_tx_dv    <= 1'b0;
            r_tx_byte  <= 8'h00;
            r_wr_stb   <= 1'b0;
            r_wr_addr  <= 4'h0;
            for (int k = 0; k < NUM_REGS; k++)
                r_cfg[k] <= 8'h00;
        end else begin
            r_tx_dv  <= 1'b0;
            r_wr_stb <= 1'b0;

            if (w_cs_rise) begin
                // End of transaction: any pending write is abandoned silently
                r_state <= ST_IDLE;
            end else if (w_cs_fall) begin
                // Preload the first MISO byte of the new transaction
                r_tx_dv   <= 1'b1;
                r_tx_byte <= IDLE_BYTE;
                r_state   <= ST_IDLE;
            end else if (w_rx_ok) begin
                r_tx_dv <= 1'b1;
                if (r_state == ST_WAIT_DATA) begin
                    // Data byte of a WRITE; never interpreted as an opcode
                    for (int k = 0; k < NUM_REGS; k++) begin
                        if (r_lat_addr == 4'(k))
                            r_cfg[k] <= i_RX_Byte;
                    end
                    r_wr_stb  <= 1'b1;
                    r_wr_addr <= r_lat_addr;
                    r_tx_byte <= ACK_BYTE;
                    r_state   <= ST_IDLE;
                end else begin
                    case (w_cmd)
                        CMD_GET_STATE: r_tx_byte <= w_state_byte;
                        CMD_GET_ERR: begin
                            r_tx_byte <= r_err_cnt;
                            r_err_cnt <= 8'h00;
                        end
                        CMD_READ: begin
                            if (w_addr_ok) begin
                                r_tx_byte <= w_rd_data;
                            end else begin
                                r_tx_byte <= ERR_BYTE;
                                r_err_cnt <= w_err_inc;
                            end
                        end
                        CMD_WRITE: begin
                            if (w_addr_ok) begin
                                r_tx_byte  <= IDLE_BYTE;
                                r_lat_addr <= w_addr;
                                r_state    <= ST_WAIT_DATA;
                            end else begin
                                r_tx_byte <= ERR_BYTE;
                                r_err_cnt <= w_err_inc;
                            end
                        end
                        CMD_NOP: r_tx_byte <= IDLE_BYTE;
                        default: begin
                            r_tx_byte <= ERR_BYTE;
                            r_err_cnt <= w_err_inc;
                        end
                    endcase
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg_pack
        assign o_Cfg[8*g +: 8] = r_cfg[g];
    end

    assign o_TX_DV       = r_tx_dv;
    assign o_TX_Byte     = r_tx_byte;
    assign o_Cfg_Wr_Stb  = r_wr_stb;
    assign o_Cfg_Wr_Addr = r_wr_addr;
    assign o_Busy        = (r_state == ST_WAIT_DATA);

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_cmd_controller
//  Brief    : Directed self-checking bench for spi_cmd_controller; expected
//             response bytes are queued when a byte is sent and compared when
//             the controller pulses o_TX_DV.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_cmd_controller;

    logic        i_Clk = 1'b0;
    logic        i_Rst;
    logic        i_SPI_CS_n;
    logic        i_RX_DV;
    logic [7:0]  i_RX_Byte;
    logic        o_TX_DV;
    logic [7:0]  o_TX_Byte;
    logic [1:0]  i_Fsm_State;
    logic [31:0] o_Cfg;
    logic        o_Cfg_Wr_Stb;
    logic [3:0]  o_Cfg_Wr_Addr;
    logic        o_Busy;

    logic [7:0]  sb [$];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 i_Clk = ~i_Clk;

    spi_cmd_controller #(
        .STATE_W   (2),
        .NUM_REGS  (4),
        .ACK_BYTE  (8'hA5),
        .ERR_BYTE  (8'hEE),
        .IDLE_BYTE (8'h00)
    ) dut (
        .i_Clk         (i_Clk),
        .i_Rst         (i_Rst),
        .i_SPI_CS_n    (i_SPI_CS_n),
        .i_RX_DV       (i_RX_DV),
        .i_RX_Byte     (i_RX_Byte),
        .o_TX_DV       (o_TX_DV),
        .o_TX_Byte     (o_TX_Byte),
        .i_Fsm_State   (i_Fsm_State),
        .o_Cfg         (o_Cfg),
        .o_Cfg_Wr_Stb  (o_Cfg_Wr_Stb),
        .o_Cfg_Wr_Addr (o_Cfg_Wr_Addr),
        .o_Busy        (o_Busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every TX pulse must match the oldest queued response
    always @(negedge i_Clk) begin
        if (i_Rst === 1'b0 && o_TX_DV === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $error("FAIL unexpected_tx: observed %0h expected no pulse", o_TX_Byte);
            end else begin
                chk("tx_byte", {24'h0, o_TX_Byte}, {24'h0, sb.pop_front()});
            end
        end
    end

    // Send one byte and require the response pulse exactly one cycle later
    task automatic rx(input logic [7:0] b, input logic [7:0] exp);
        @(negedge i_Clk);
        i_RX_DV   = 1'b1;
        i_RX_Byte = b;
        sb.push_back(exp);
        @(negedge i_Clk);
        i_RX_DV = 1'b0;
        chk("tx_latency", {31'h0, o_TX_DV}, 32'h1);
    endtask

    // Send one byte that must be ignored (no response pulse)
    task automatic rx_ignored(input logic [7:0] b);
        @(negedge i_Clk);
        i_RX_DV   = 1'b1;
        i_RX_Byte = b;
        @(negedge i_Clk);
        i_RX_DV = 1'b0;
        chk("ignored_no_tx", {31'h0, o_TX_DV}, 32'h0);
        @(negedge i_Clk);
        chk("ignored_no_tx2", {31'h0, o_TX_DV}, 32'h0);
    endtask

    // Wait (bounded) for the IDLE_BYTE preload that follows a synchronized CS fall
    task automatic wait_preload();
        logic seen;
        seen = 1'b0;
        sb.push_back(8'h00);
        for (int i = 0; i < 8; i++) begin
            @(negedge i_Clk);
            if (o_TX_DV === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("cs_fall_preload", {31'h0, seen}, 32'h1);
    endtask

    task automatic cs_low();
        @(negedge i_Clk);
        i_SPI_CS_n = 1'b0;
        wait_preload();
    endtask

    // Raise CS and watch that no write strobe or response appears
    task automatic cs_high();
        @(negedge i_Clk);
        i_SPI_CS_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_Clk);
            chk("abort_no_stb", {31'h0, o_Cfg_Wr_Stb}, 32'h0);
        end
    endtask

    initial begin
        i_Rst       = 1'b1;
        i_SPI_CS_n  = 1'b1;
        i_RX_DV     = 1'b0;
        i_RX_Byte   = 8'h00;
        i_Fsm_State = 2'b00;

        // Reset state
        repeat (3) @(negedge i_Clk);
        chk("rst_tx_dv",   {31'h0, o_TX_DV},       32'h0);
        chk("rst_tx_byte", {24'h0, o_TX_Byte},     32'h0);
        chk("rst_cfg",     o_Cfg,                  32'h0);
        chk("rst_stb",     {31'h0, o_Cfg_Wr_Stb},  32'h0);
        chk("rst_addr",    {28'h0, o_Cfg_Wr_Addr}, 32'h0);
        chk("rst_busy",    {31'h0, o_Busy},        32'h0);
        i_Rst = 1'b0;
        repeat (2) @(negedge i_Clk);

        // Transaction start preloads IDLE_BYTE
        cs_low();

        // GET_STATE zero-extends the application state
        i_Fsm_State = 2'b10;
        rx(8'hFF, 8'h02);
        i_Fsm_State = 2'b00;

        // WRITE reg2 = 5A, then read it back
        rx(8'h42, 8'h00);
        chk("busy_after_write_op", {31'h0, o_Busy}, 32'h1);
        rx(8'h5A, 8'hA5);
        chk("wr_stb",         {31'h0, o_Cfg_Wr_Stb},  32'h1);
        chk("wr_addr",        {28'h0, o_Cfg_Wr_Addr}, 32'h2);
        chk("reg2_written",   {24'h0, o_Cfg[23:16]},  32'h5A);
        chk("busy_after_data",{31'h0, o_Busy},        32'h0);
        @(negedge i_Clk);
        chk("wr_stb_one_cycle", {31'h0, o_Cfg_Wr_Stb}, 32'h0);
        rx(8'h82, 8'h5A);

        // Out-of-range WRITE and illegal opcode both error; GET_ERR reads then clears
        rx(8'h47, 8'hEE);
        chk("bad_write_not_busy", {31'h0, o_Busy}, 32'h0);
        rx(8'hC3, 8'hEE);
        rx(8'hFE, 8'h02);
        rx(8'hFE, 8'h00);

        // NOP, boundary addresses 0 and 3, READ at address 4 errors
        rx(8'h00, 8'h00);
        rx(8'h40, 8'h00);
        rx(8'h3C, 8'hA5);
        rx(8'h43, 8'h00);
        rx(8'h99, 8'hA5);
        chk("wr_addr3", {28'h0, o_Cfg_Wr_Addr}, 32'h3);
        chk("cfg_all",  o_Cfg, 32'h995A003C);
        rx(8'h80, 8'h3C);
        rx(8'h83, 8'h99);
        rx(8'h84, 8'hEE);
        rx(8'hFE, 8'h01);

        // Abort a WRITE with CS high: no write, err_cnt kept
        rx(8'hC3, 8'hEE);
        rx(8'h41, 8'h00);
        chk("busy_before_abort", {31'h0, o_Busy}, 32'h1);
        cs_high();
        chk("abort_busy_low", {31'h0, o_Busy}, 32'h0);
        chk("abort_reg1_kept", {24'h0, o_Cfg[15:8]}, 32'h0);
        chk("abort_cfg_kept", o_Cfg, 32'h995A003C);
        rx_ignored(8'hFF);
        cs_low();
        rx(8'hFE, 8'h01);

        // Error counter saturates at FF
        for (int i = 0; i < 300; i++)
            rx(8'hC0, 8'hEE);
        rx(8'hFE, 8'hFF);
        rx(8'hFE, 8'h00);

        // Asynchronous reset during WAIT_DATA
        rx(8'h41, 8'h00);
        chk("busy_before_rst", {31'h0, o_Busy}, 32'h1);
        #2;
        i_Rst = 1'b1;
        #1;
        chk("async_rst_cfg",  o_Cfg,                 32'h0);
        chk("async_rst_busy", {31'h0, o_Busy},       32'h0);
        chk("async_rst_txdv", {31'h0, o_TX_DV},      32'h0);
        chk("async_rst_byte", {24'h0, o_TX_Byte},    32'h0);
        chk("async_rst_stb",  {31'h0, o_Cfg_Wr_Stb}, 32'h0);
        repeat (2) @(negedge i_Clk);
        i_Rst = 1'b0;
        wait_preload();

        // First byte after reset is an opcode, not the dropped write's data
        rx(8'h42, 8'h00);
        chk("post_rst_busy", {31'h0, o_Busy}, 32'h1);
        rx(8'h11, 8'hA5);
        chk("post_rst_addr", {28'h0, o_Cfg_Wr_Addr}, 32'h2);
        chk("post_rst_cfg",  o_Cfg, 32'h00110000);
        rx(8'h82, 8'h11);

        repeat (3) @(negedge i_Clk);
        chk("sb_drained", sb.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
